// File: rtl/sync_queue.sv
// Single-clock show-ahead FIFO with wrap-bit pointers and decoded full/empty status.
// Optional sticky illegal-request flag on error_out when QUEUE_ERR_EN is defined.
module sync_queue #(
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wdata_in,
    input  logic                  enqueue_in,
    output logic [DATA_WIDTH-1:0] rdata_out,
    input  logic                  dequeue_in,
    output logic                  full_out,
`ifdef QUEUE_ERR_EN
    output logic                  empty_out,
    output logic                  error_out
`else
    output logic                  empty_out
`endif
);

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [QUEUE_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q;
    logic [PW-1:0]         rd_ptr_d;
    logic                  full_s;
    logic                  empty_s;
    logic                  enq_ok_s;
    logic                  deq_ok_s;

    // Status decode: equal low bits with differing wrap bits means full.
    always_comb begin
        empty_s  = (wr_ptr_q == rd_ptr_q);
        full_s   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
        enq_ok_s = enqueue_in & ~full_s;
        deq_ok_s = dequeue_in & ~empty_s;
    end

    // Pointer next-state; each pointer advances only on an accepted request.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (enq_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (deq_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers; reset empties the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, deliberately left unreset.
    always_ff @(posedge clk) begin
        if (enq_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_in;
        end
    end

    // Show-ahead head word, forced to zero while empty.
    always_comb begin
        full_out  = full_s;
        empty_out = empty_s;
        if (empty_s) begin
            rdata_out = {DATA_WIDTH{1'b0}};
        end else begin
            rdata_out = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

`ifdef QUEUE_ERR_EN
    logic error_q;
    logic error_d;

    // Sticky flag for any request that the current status refuses.
    always_comb begin
        error_d = error_q;
        if ((enqueue_in && full_s) || (dequeue_in && empty_s)) begin
            error_d = 1'b1;
        end else begin
            error_d = error_q;
        end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error_out = error_q;
`endif

endmodule

// File: tb/tb_sync_queue.sv
// Directed self-checking bench for sync_queue (default 32 x 64 configuration).
module tb_sync_queue;

    logic        clk;
    logic        rst;
    logic [31:0] wdata_in;
    logic        enqueue_in;
    logic [31:0] rdata_out;
    logic        dequeue_in;
    logic        full_out;
    logic        empty_out;
`ifdef QUEUE_ERR_EN
    logic        error_out;
`endif

    int total_cnt;
    int bad_cnt;

    sync_queue #(.DATA_WIDTH(32), .QUEUE_DEPTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .wdata_in   (wdata_in),
        .enqueue_in (enqueue_in),
        .rdata_out  (rdata_out),
        .dequeue_in (dequeue_in),
        .full_out   (full_out),
`ifdef QUEUE_ERR_EN
        .empty_out  (empty_out),
        .error_out  (error_out)
`else
        .empty_out  (empty_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (obs !== exp) begin
            bad_cnt = bad_cnt + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic [31:0] rd, input logic full_e, input logic empty_e);
        check_val({tag, ".rdata"}, rdata_out, rd);
        check_val({tag, ".full"}, 32'(full_out), 32'(full_e));
        check_val({tag, ".empty"}, 32'(empty_out), 32'(empty_e));
    endtask

    initial begin
        total_cnt  = 0;
        bad_cnt    = 0;
        rst        = 1'b0;
        wdata_in   = 32'h0;
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;

        // reset held two cycles, then released
        tick();
        tick();
        check_status("reset", 32'h0, 1'b0, 1'b1);
`ifdef QUEUE_ERR_EN
        check_val("reset.err", 32'(error_out), 32'h0);
`endif
        rst = 1'b1;
        tick();
        check_status("post_reset", 32'h0, 1'b0, 1'b1);

        // single word
        wdata_in = 32'hcafebabe; enqueue_in = 1'b1;
        tick();
        enqueue_in = 1'b0;
        check_status("single_enq", 32'hcafebabe, 1'b0, 1'b0);
        dequeue_in = 1'b1;
        tick();
        dequeue_in = 1'b0;
        check_status("single_deq", 32'h0, 1'b0, 1'b1);

        // fill 0..63
        for (int i = 0; i < 64; i++) begin
            wdata_in = i; enqueue_in = 1'b1;
            tick();
            if (i == 62) check_status("fill_63", 32'h0, 1'b0, 1'b0);
        end
        check_status("fill_full", 32'h0, 1'b1, 1'b0);
        wdata_in = 32'hdeadbeef;
        tick();
        enqueue_in = 1'b0;
        check_status("overflow_drop", 32'h0, 1'b1, 1'b0);
`ifdef QUEUE_ERR_EN
        check_val("overflow.err", 32'(error_out), 32'h1);
`endif
        for (int i = 0; i < 64; i++) begin
            check_val($sformatf("drain_%0d", i), rdata_out, i);
            dequeue_in = 1'b1;
            tick();
        end
        dequeue_in = 1'b0;
        check_status("drained", 32'h0, 1'b0, 1'b1);

        // enqueue+dequeue while empty -> enqueue only
        wdata_in = 32'h77; enqueue_in = 1'b1; dequeue_in = 1'b1;
        tick();
        enqueue_in = 1'b0;
        check_status("empty_both", 32'h77, 1'b0, 1'b0);
        tick();
        dequeue_in = 1'b0;
        check_status("empty_both_out", 32'h0, 1'b0, 1'b1);

        // dequeue while empty -> no change
        dequeue_in = 1'b1;
        tick();
        dequeue_in = 1'b0;
        check_status("underflow", 32'h0, 1'b0, 1'b1);
        wdata_in = 32'h99; enqueue_in = 1'b1;
        tick();
        enqueue_in = 1'b0;
        check_status("underflow_then_enq", 32'h99, 1'b0, 1'b0);
        dequeue_in = 1'b1;
        tick();
        dequeue_in = 1'b0;

        // full, then enqueue+dequeue -> dequeue only (crosses pointer wrap)
        for (int i = 0; i < 64; i++) begin
            wdata_in = 32'h100 + i; enqueue_in = 1'b1;
            tick();
        end
        check_status("refill_full", 32'h100, 1'b1, 1'b0);
        wdata_in = 32'h0bad; dequeue_in = 1'b1;
        tick();
        enqueue_in = 1'b0;
        check_status("full_both", 32'h101, 1'b0, 1'b0);
        for (int i = 1; i < 64; i++) begin
            check_val($sformatf("full_drain_%0d", i), rdata_out, 32'h100 + i);
            tick();
        end
        dequeue_in = 1'b0;
        check_status("full_drained", 32'h0, 1'b0, 1'b1);

        // simultaneous enqueue/dequeue at occupancy 3
        enqueue_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wdata_in = 32'ha1 + i;
            tick();
        end
        wdata_in = 32'h11; dequeue_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check_val($sformatf("simul_%0d", k), rdata_out, (k < 3) ? (32'ha1 + k) : 32'h11);
            tick();
        end
        enqueue_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("simul_tail_%0d", k), rdata_out, 32'h11);
            tick();
        end
        dequeue_in = 1'b0;
        check_status("simul_empty", 32'h0, 1'b0, 1'b1);
`ifdef QUEUE_ERR_EN
        check_val("sticky.err", 32'(error_out), 32'h1);
`endif

        // async reset mid-fill
        enqueue_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wdata_in = 32'h200 + i;
            tick();
        end
        enqueue_in = 1'b0;
        check_status("prefill", 32'h200, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_status("async_rst", 32'h0, 1'b0, 1'b1);
`ifdef QUEUE_ERR_EN
        check_val("async_rst.err", 32'(error_out), 32'h0);
`endif
        #1 rst = 1'b1;
        wdata_in = 32'h5; enqueue_in = 1'b1;
        tick();
        enqueue_in = 1'b0;
        check_status("after_rst", 32'h5, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
